// File: rtl/merge_data_nch.sv
// Serial-to-parallel frame merger: MSB-first bits into NUM_CH x WIDTH frames on a valid/ready output.
// Optional even-parity trailer per frame when MERGE_DATA_NCH_PARITY_CHECK_EN is defined.
module merge_data_nch #(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      bit_valid_i,
  input  logic                      bit_i,
  output logic [NUM_CH*WIDTH-1:0]   data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      overflow_o,
  output logic                      parity_err_o,
  output logic [CNT_W-1:0]          frame_cnt_o
);

  localparam int FW  = NUM_CH * WIDTH;
  localparam int BCW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int CCW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [CCW-1:0] CH_LAST  = CCW'(NUM_CH - 1);

`ifdef MERGE_DATA_NCH_PARITY_CHECK_EN
  // The whole frame must survive one extra bit time for the parity check.
  localparam int SRW = FW;
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PARITY} state_t;
`else
  // Once a frame completes the oldest bit is never read again, so FW-1 history bits suffice.
  localparam int SRW = FW - 1;
  typedef enum logic [1:0] {S_IDLE, S_COLLECT} state_t;
`endif

  // Output handshake: data_o is offered while valid_o=1 and is taken on any
  // rising edge where valid_o && ready_i; data_o never changes while valid_o=1
  // unless that same edge also accepts the previous frame.

  state_t           state_q, state_d;
  logic [SRW-1:0]   shreg_q, shreg_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CCW-1:0]   ch_cnt_q, ch_cnt_d;
  logic [FW-1:0]    data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             perr_q, perr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [FW-1:0]    shift_word;
  logic [FW-1:0]    cand;
  logic             cand_rdy;
  logic             last_bit;

  assign shift_word = {shreg_q[FW-2:0], bit_i};
  assign last_bit   = (bit_cnt_q == BIT_LAST) && (ch_cnt_q == CH_LAST);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    ch_cnt_d  = ch_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    perr_d    = 1'b0;
    cnt_d     = cnt_q;
    cand      = shift_word;
    cand_rdy  = 1'b0;

    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (!start_i) begin
          state_d   = S_IDLE;
          shreg_d   = '0;
          bit_cnt_d = '0;
          ch_cnt_d  = '0;
        end else if (bit_valid_i) begin
          shreg_d = shift_word[SRW-1:0];
          if (last_bit) begin
            bit_cnt_d = '0;
            ch_cnt_d  = '0;
`ifdef MERGE_DATA_NCH_PARITY_CHECK_EN
            state_d   = S_PARITY;
`else
            cand      = shift_word;
            cand_rdy  = 1'b1;
`endif
          end else if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            ch_cnt_d  = ch_cnt_q + 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef MERGE_DATA_NCH_PARITY_CHECK_EN
      S_PARITY: begin
        if (!start_i) begin
          state_d   = S_IDLE;
          shreg_d   = '0;
          bit_cnt_d = '0;
          ch_cnt_d  = '0;
        end else if (bit_valid_i) begin
          state_d = S_COLLECT;
          shreg_d = '0;
          // Even parity: data ones plus the parity bit must total an even count.
          if ((^shreg_q) == bit_i) begin
            cand     = shreg_q;
            cand_rdy = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (!start_i) begin
      ovf_d = 1'b0;
    end

    if (cand_rdy) begin
      if (!valid_q || ready_i) begin
        data_d  = cand;
        valid_d = 1'b1;
        cnt_d   = cnt_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      ch_cnt_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      perr_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      ch_cnt_q  <= ch_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      perr_q    <= perr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign overflow_o   = ovf_q;
  assign parity_err_o = perr_q;
  assign frame_cnt_o  = cnt_q;

endmodule

// File: tb/tb_merge_data_nch.sv
// Bench for merge_data_nch: directed frames plus randomized bits/gaps/backpressure/aborts
// checked every cycle against a queue-based frame model and a delivery scoreboard.
module tb_merge_data_nch;

  localparam int WIDTH  = 4;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 4;
  localparam int FW     = WIDTH * NUM_CH;
`ifdef MERGE_DATA_NCH_PARITY_CHECK_EN
  localparam int FLEN = FW + 1;
`else
  localparam int FLEN = FW;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic             bit_valid_i = 1'b0;
  logic             bit_i = 1'b0;
  logic             ready_i = 1'b0;
  logic [FW-1:0]    data_o;
  logic             valid_o;
  logic             overflow_o;
  logic             parity_err_o;
  logic [CNT_W-1:0] frame_cnt_o;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state: bits of the frame in progress plus the output-side view.
  bit               m_active = 1'b0;
  logic             bitq[$];
  logic             m_valid = 1'b0;
  logic [FW-1:0]    m_data = '0;
  logic             m_ovf = 1'b0;
  logic             m_perr = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic [FW-1:0]    exp_q[$];

  merge_data_nch #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .bit_valid_i  (bit_valid_i),
    .bit_i        (bit_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .overflow_o   (overflow_o),
    .parity_err_o (parity_err_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, evaluated on the rising edge from the inputs driven earlier in the cycle.
  always @(posedge clk or negedge rst) begin : model
    logic          perr_n;
    logic          load;
    logic          accepted;
    logic [FW-1:0] cand;
    int            ones;
    if (!rst) begin
      m_active = 1'b0;
      bitq.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_ovf   = 1'b0;
      m_perr  = 1'b0;
      m_cnt   = '0;
      exp_q.delete();
    end else begin
      perr_n   = 1'b0;
      load     = 1'b0;
      accepted = m_valid && ready_i;
      cand     = '0;
      if (!start_i) begin
        m_active = 1'b0;
        bitq.delete();
        m_ovf = 1'b0;
      end else if (!m_active) begin
        m_active = 1'b1;
      end else if (bit_valid_i) begin
        bitq.push_back(bit_i);
        if (bitq.size() == FLEN) begin
          ones = 0;
          for (int i = 0; i < FLEN; i++) ones += int'(bitq[i]);
          for (int i = 0; i < FW; i++) cand = {cand[FW-2:0], bitq[i]};
          if ((FLEN == FW) || (ones % 2 == 0)) begin
            if (!m_valid || ready_i) load = 1'b1;
            else m_ovf = 1'b1;
          end else begin
            perr_n = 1'b1;
          end
          bitq.delete();
        end
      end
      if (load) begin
        m_valid = 1'b1;
        m_data  = cand;
        m_cnt   = m_cnt + 1'b1;
        exp_q.push_back(cand);
      end else if (accepted) begin
        m_valid = 1'b0;
      end
      m_perr = perr_n;
    end
  end

  // Compare process plus delivery scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst && cmp_en) begin
      chk("data_o",       32'(data_o),       32'(m_data));
      chk("valid_o",      32'(valid_o),      32'(m_valid));
      chk("overflow_o",   32'(overflow_o),   32'(m_ovf));
      chk("parity_err_o", 32'(parity_err_o), 32'(m_perr));
      chk("frame_cnt_o",  32'(frame_cnt_o),  32'(m_cnt));
      if (valid_o && ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_delivery: got %0h expected no frame at %0t", data_o, $time);
        end else begin
          logic [FW-1:0] e;
          e = exp_q.pop_front();
          if (data_o !== e) begin
            errors++;
            $display("FAIL sb_delivery: got %0h expected %0h at %0t", data_o, e, $time);
          end
        end
      end
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic step(input logic st, input logic bv, input logic b, input logic rdy);
    start_i     = st;
    bit_valid_i = bv;
    bit_i       = b;
    ready_i     = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [FW-1:0] f, input int gap, input logic rdy,
                            input logic rdy_last, input logic bad_par);
    logic b;
    for (int i = 0; i < FLEN; i++) begin
      if (i > 0)
        for (int g = 0; g < gap; g++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), rdy);
      b = (i < FW) ? f[FW-1-i] : ((^f) ^ bad_par);
      step(1'b1, 1'b1, b, (i == FLEN - 1) ? rdy_last : rdy);
    end
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset data_o", 32'(data_o), 32'h0);
    chk("reset valid_o", 32'(valid_o), 32'h0);
    chk("reset overflow_o", 32'(overflow_o), 32'h0);
    chk("reset parity_err_o", 32'(parity_err_o), 32'h0);
    chk("reset frame_cnt_o", 32'(frame_cnt_o), 32'h0);
    rst    = 1'b1;
    cmp_en = 1'b1;

    // Consecutive bits, always ready
    step(1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(8'hA3, 0, 1'b1, 1'b1, 1'b0);
    chk("t1 valid", 32'(valid_o), 32'h1);
    chk("t1 data", 32'(data_o), 32'hA3);
    chk("t1 cnt", 32'(frame_cnt_o), 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t1 valid drop", 32'(valid_o), 32'h0);
    chk("t1 data hold", 32'(data_o), 32'hA3);

    // Bit gaps every other cycle
    send_frame(8'hA3, 1, 1'b1, 1'b1, 1'b0);
    chk("t2 valid", 32'(valid_o), 32'h1);
    chk("t2 data", 32'(data_o), 32'hA3);
    chk("t2 cnt", 32'(frame_cnt_o), 32'h2);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // Backpressure overflow
    send_frame(8'hA3, 0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5C, 0, 1'b0, 1'b0, 1'b0);
    chk("t3 data", 32'(data_o), 32'hA3);
    chk("t3 overflow", 32'(overflow_o), 32'h1);
    chk("t3 cnt", 32'(frame_cnt_o), 32'h3);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t3 valid drop", 32'(valid_o), 32'h0);
    chk("t3 overflow sticky", 32'(overflow_o), 32'h1);

    // Ready on the exact completing edge of the second frame
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4 overflow clear", 32'(overflow_o), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h0F, 0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF0, 0, 1'b0, 1'b1, 1'b0);
    chk("t4 data", 32'(data_o), 32'hF0);
    chk("t4 valid", 32'(valid_o), 32'h1);
    chk("t4 overflow", 32'(overflow_o), 32'h0);
    chk("t4 cnt", 32'(frame_cnt_o), 32'h5);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // Partial frame abort
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(8'h81, 0, 1'b1, 1'b1, 1'b0);
    chk("t5 data", 32'(data_o), 32'h81);
    chk("t5 cnt", 32'(frame_cnt_o), 32'h6);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("t5 async data", 32'(data_o), 32'h0);
    chk("t5 async valid", 32'(valid_o), 32'h0);
    chk("t5 async cnt", 32'(frame_cnt_o), 32'h0);
    chk("t5 async overflow", 32'(overflow_o), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b1);

`ifdef MERGE_DATA_NCH_PARITY_CHECK_EN
    send_frame(8'hA3, 0, 1'b1, 1'b1, 1'b0);
    chk("t6 good valid", 32'(valid_o), 32'h1);
    chk("t6 good data", 32'(data_o), 32'hA3);
    chk("t6 good cnt", 32'(frame_cnt_o), 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(8'hA3, 0, 1'b1, 1'b1, 1'b1);
    chk("t6 bad perr", 32'(parity_err_o), 32'h1);
    chk("t6 bad valid", 32'(valid_o), 32'h0);
    chk("t6 bad cnt", 32'(frame_cnt_o), 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t6 perr pulse", 32'(parity_err_o), 32'h0);
`endif

    // Randomized bits, gaps, backpressure and occasional aborts
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 59) == 0)
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        step(1'b1, ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/merge_data_nch.md
Name: merge_data_nch

Overview:
- Parametrised successor to the two-channel UART bit merger in the FM demodulator loopback path.
- Collects a serial bitstream, one bit per enabled cycle, MSB-first, into frames of NUM_CH channels of WIDTH bits each (e.g. I/Q or multi-carrier samples).
- Presents each completed frame on a registered valid/ready interface to split/processing stages.
- Adds partial-frame abort, backpressure with overflow detection, and a frame counter.

Parameters:
- WIDTH, 16: bits per channel sample.
- NUM_CH, 2: channels per frame; frame width FW = NUM_CH*WIDTH.
- CNT_W, 16: width of the delivered-frame counter.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous active-low reset.
- start_i, input, 1: enable; low aborts collection and holds the block idle.
- bit_valid_i, input, 1: bit_i is sampled on this cycle's rising edge.
- bit_i, input, 1: serial data bit, MSB of channel 0 first.
- data_o, output, FW: frame; channel 0 in [FW-1:FW-WIDTH], channel NUM_CH-1 in [WIDTH-1:0].
- valid_o, output, 1: data_o holds an undelivered frame.
- ready_i, input, 1: downstream accepts data_o when valid_o && ready_i.
- overflow_o, output, 1: sticky; a completed frame was dropped.
- parity_err_o, output, 1: one-cycle pulse on parity failure (PARITY_CHECK_EN only, else 0).
- frame_cnt_o, output, CNT_W: count of frames loaded into data_o; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst low, asynchronous):
  - all outputs 0 (data_o, valid_o, overflow_o, parity_err_o, frame_cnt_o);
  - shift register and counters cleared;
  - state IDLE.
- States: IDLE, COLLECT, PARITY (PARITY exists only with the macro).
- IDLE -> COLLECT when start_i=1. No bits are sampled in the IDLE cycle.
- COLLECT:
  - on each edge with bit_valid_i=1, shift left: shreg <= {shreg[FW-2:0], bit_i};
  - bit_cnt counts 0..WIDTH-1, ch_cnt counts 0..NUM_CH-1;
  - bit_cnt wraps into ch_cnt increment.
- Frame completion: on the edge sampling bit FW-1 (bit_cnt=WIDTH-1 and ch_cnt=NUM_CH-1):
  - counters return to 0 and the state stays COLLECT for back-to-back frames;
  - the completed word {shreg[FW-2:0], bit_i} is the candidate frame.
- Load rule: the candidate frame is loaded into data_o when valid_o=0, or when valid_o=1 && ready_i=1 on the same edge.
  - On load: valid_o <= 1, frame_cnt_o increments.
  - Latency: valid_o is visible in the cycle after the last bit's edge.
- Overflow: candidate frame ready while valid_o=1 && ready_i=0:
  - candidate dropped; data_o and valid_o unchanged;
  - overflow_o <= 1 and stays 1 until reset or start_i=0.
- Handshake:
  - valid_o && ready_i with no new load: valid_o <= 0 next edge;
  - data_o holds its value (not cleared) after acceptance;
  - data_o is stable while valid_o=1.
- Abort: start_i=0 in COLLECT or PARITY:
  - state <= IDLE, counters and shreg cleared, partial frame discarded;
  - overflow_o cleared;
  - a pending valid_o/data_o frame is kept and still deliverable.
- bit_valid_i=0 cycles: no state or counter change; gaps of any length are allowed mid-frame.
- frame_cnt_o wraps from 2^CNT_W-1 to 0 without a flag.

Optional Feature:
- Macro: MERGE_DATA_NCH_PARITY_CHECK_EN.
- Defined:
  - after bit FW-1, go to PARITY instead of loading;
  - the next valid bit is an even-parity bit over the FW data bits;
  - on match: load per the load rule on that edge;
  - on mismatch: drop the frame, parity_err_o=1 for exactly one cycle, frame_cnt_o unchanged, overflow_o unaffected;
  - return to COLLECT.
- Undefined: no PARITY state, parity_err_o tied 0, frames are exactly FW bits.

Test Plan:
1. WIDTH=4, NUM_CH=2, ready_i=1, bits 1010_0011 on consecutive cycles -> data_o=8'hA3, valid_o high for 1 cycle after the 8th bit edge, frame_cnt_o=1.
2. Same stream with bit_valid_i toggling 1/0 every cycle -> identical data_o=8'hA3, valid_o 16 cycles after the first bit.
3. ready_i=0, two frames 8'hA3 then 8'h5C back-to-back -> data_o stays 8'hA3, overflow_o=1, frame_cnt_o=1. Raise ready_i -> valid_o drops next cycle.
4. ready_i pulsed high on the exact edge of frame 2's last bit, after frame 1 (8'h0F) is pending -> data_o=8'hF0 with valid_o held high, overflow_o=0, frame_cnt_o=2.
5. start_i dropped after 5 bits, then raised, then full frame 8'h81 -> data_o=8'h81, no trace of the partial bits. A separate rst pulse mid-frame -> all outputs 0 immediately, asynchronous to clk.
6. With macro: 8'hA3 + parity 0 -> loaded. 8'hA3 + parity 1 -> parity_err_o one-cycle pulse, valid_o stays 0, frame_cnt_o unchanged.
